// File: rtl/fr_pkg.sv
// Shared opcodes, command-word field positions and FSM state type for the
// micro-to-datapath command register file.
package fr_pkg;

  localparam logic [7:0] OP_RESET    = 8'h01;
  localparam logic [7:0] OP_EN_TX    = 8'h02;
  localparam logic [7:0] OP_EN_RX    = 8'h03;
  localparam logic [7:0] OP_PH_SEL   = 8'h04;
  localparam logic [7:0] OP_RUN_MEM  = 8'h05;
  localparam logic [7:0] OP_RD_MEM   = 8'h06;
  localparam logic [7:0] OP_IS_FULL  = 8'h07;
  localparam logic [7:0] OP_BER_S    = 8'h08;
  localparam logic [7:0] OP_BER_E    = 8'h0A;
  localparam logic [7:0] OP_BER_HIGH = 8'h0C;
  localparam logic [7:0] OP_STATUS   = 8'h0D;

  localparam int unsigned NB_CHAN  = 7;
  localparam int unsigned NB_VAL   = 16;
  localparam int unsigned VAL_LSB  = 0;
  localparam logic [NB_CHAN-1:0] BROADCAST = 7'h7F;

  typedef enum logic {IDLE, MEM_WAIT} fr_state_t;

endpackage

// File: rtl/fr_ber_mux.sv
// Channel-indexed select of a 64-bit BER sample or error count; channels
// outside 0..NCH-1 (including broadcast) yield zero.
module fr_ber_mux #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned NB_BER = 64
) (
  input  logic [NCH*NB_BER-1:0] samp,
  input  logic [NCH*NB_BER-1:0] err,
  input  logic [6:0]            chan,
  input  logic                  sel_err,
  output logic [NB_BER-1:0]     ber_c,
  output logic                  in_range_c
);

  always_comb begin
    ber_c      = '0;
    in_range_c = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (chan == 7'(k)) begin
        in_range_c = 1'b1;
        ber_c      = sel_err ? err[k*NB_BER +: NB_BER] : samp[k*NB_BER +: NB_BER];
      end
    end
  end

endmodule

// File: rtl/file_register_nch.sv
// Command register file: decodes strobed GPO words from the soft micro into
// per-channel controls, log-memory reads and BER readback. Optional sticky
// error flags with a STATUS opcode are enabled by defining FR_ERR_FLAG_EN.
module file_register_nch
  import fr_pkg::*;
#(
  parameter int unsigned NB_CMD    = 8,
  parameter int unsigned NB_DATA   = 24,
  parameter int unsigned NB_INST   = 32,
  parameter int unsigned NB_BER    = 64,
  parameter int unsigned NCH       = 2,
  parameter int unsigned NB_PHASE  = 2,
  parameter int unsigned NB_ADDR   = 15,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned RST_PULSE = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NB_INST-1:0]      i_cmd_from_micro,
  output logic [NB_INST-1:0]      o_data_to_micro,
  input  logic                    i_mem_full,
  input  logic [NCH*NB_BER-1:0]   i_ber_samp,
  input  logic [NCH*NB_BER-1:0]   i_ber_error,
  input  logic [NB_INST-1:0]      i_data_log_from_mem,
  output logic                    o_reset,
  output logic [NCH-1:0]          o_enb_tx,
  output logic [NCH-1:0]          o_enb_rx,
  output logic [NCH*NB_PHASE-1:0] o_phase_sel,
  output logic                    o_run_log,
  output logic                    o_read_log,
  output logic [NB_ADDR-1:0]      o_addr_log_to_mem
);

  localparam int unsigned NB_LAT = $clog2(MEM_LAT + 1);
  localparam int unsigned NB_RST = $clog2(RST_PULSE + 1);

  logic [7:0]         op_c;
  logic               strobe_c;
  logic [NB_CHAN-1:0] chan;
  logic [NB_VAL-1:0]  val;
  logic               unused_bits;

  assign op_c        = 8'(i_cmd_from_micro[NB_INST-1 -: NB_CMD]);
  assign strobe_c    = i_cmd_from_micro[NB_DATA-1];
  assign chan        = i_cmd_from_micro[NB_DATA-2 -: NB_CHAN];
  assign val         = i_cmd_from_micro[VAL_LSB +: NB_VAL];
  assign unused_bits = ^{val};

  fr_state_t          state;
  logic               strobe_d;
  logic [NB_LAT-1:0]  lat_cnt;
  logic [NB_RST-1:0]  rst_cnt;
  logic [NB_BER-1:0]  shadow;

  logic               edge_c;
  logic               exec_c;
  logic               chan_ok_c;
  logic [NB_BER-1:0]  ber_c;
  logic               ber_ok_c;

  assign edge_c    = strobe_c & ~strobe_d;
  assign exec_c    = edge_c & (state == IDLE);
  assign chan_ok_c = (chan == BROADCAST) || (32'(chan) < NCH);

  fr_ber_mux #(.NCH(NCH), .NB_BER(NB_BER)) u_ber_mux (
    .samp       (i_ber_samp),
    .err        (i_ber_error),
    .chan       (chan),
    .sel_err    (op_c == OP_BER_E),
    .ber_c      (ber_c),
    .in_range_c (ber_ok_c)
  );

`ifdef FR_ERR_FLAG_EN
  // Sticky flags {overrun, bad_chan, bad_cmd}; STATUS clears, same-cycle errors win.
  logic [2:0] flags;
  logic       bad_cmd_c;
  logic       bad_chan_c;
  logic       overrun_c;
  logic       status_c;

  assign status_c   = exec_c & (op_c == OP_STATUS);
  assign overrun_c  = edge_c & (state == MEM_WAIT);
  assign bad_cmd_c  = exec_c & !(op_c inside {OP_RESET, OP_EN_TX, OP_EN_RX, OP_PH_SEL,
                                              OP_RUN_MEM, OP_RD_MEM, OP_IS_FULL, OP_BER_S,
                                              OP_BER_E, OP_BER_HIGH, OP_STATUS});
  assign bad_chan_c = exec_c & (((op_c inside {OP_EN_TX, OP_EN_RX, OP_PH_SEL}) & !chan_ok_c) |
                                ((op_c inside {OP_BER_S, OP_BER_E}) & !ber_ok_c));

  always_ff @(posedge clock) begin
    if (reset) flags <= 3'b000;
    else       flags <= (status_c ? 3'b000 : flags) | {overrun_c, bad_chan_c, bad_cmd_c};
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      strobe_d          <= 1'b1;
      lat_cnt           <= '0;
      rst_cnt           <= '0;
      shadow            <= '0;
      o_data_to_micro   <= '0;
      o_reset           <= 1'b0;
      o_enb_tx          <= '0;
      o_enb_rx          <= '0;
      o_phase_sel       <= '0;
      o_run_log         <= 1'b0;
      o_read_log        <= 1'b0;
      o_addr_log_to_mem <= '0;
    end else begin
      strobe_d   <= strobe_c;
      o_read_log <= 1'b0;

      if (o_reset) begin
        if (rst_cnt == '0) o_reset <= 1'b0;
        else               rst_cnt <= rst_cnt - 1'b1;
      end

      case (state)
        IDLE: if (exec_c) begin
          case (op_c)
            OP_RESET: begin
              o_reset <= 1'b1;
              rst_cnt <= NB_RST'(RST_PULSE - 1);
            end
            OP_EN_TX, OP_EN_RX, OP_PH_SEL: begin
              for (int k = 0; k < int'(NCH); k++) begin
                if (chan == BROADCAST || chan == 7'(k)) begin
                  if (op_c == OP_EN_TX) o_enb_tx[k] <= val[0];
                  if (op_c == OP_EN_RX) o_enb_rx[k] <= val[0];
                  if (op_c == OP_PH_SEL) o_phase_sel[k*NB_PHASE +: NB_PHASE] <= val[NB_PHASE-1:0];
                end
              end
            end
            OP_RUN_MEM: o_run_log <= val[0];
            OP_RD_MEM: begin
              o_read_log        <= 1'b1;
              o_addr_log_to_mem <= val[NB_ADDR-1:0];
              lat_cnt           <= NB_LAT'(MEM_LAT - 1);
              state             <= MEM_WAIT;
            end
            OP_IS_FULL: o_data_to_micro <= NB_INST'(i_mem_full);
            OP_BER_S, OP_BER_E: begin
              shadow          <= ber_c;
              o_data_to_micro <= ber_c[NB_INST-1:0];
            end
            OP_BER_HIGH: o_data_to_micro <= shadow[NB_BER-1 -: NB_INST];
`ifdef FR_ERR_FLAG_EN
            OP_STATUS: o_data_to_micro <= NB_INST'(flags);
`endif
            default: ;
          endcase
        end
        // Edges arriving here are dropped; data is captured on the last wait cycle.
        MEM_WAIT: begin
          if (lat_cnt == '0) begin
            o_data_to_micro <= i_data_log_from_mem;
            state           <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_file_register_nch.sv
// Scoreboard bench for file_register_nch: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_file_register_nch;
  import fr_pkg::*;

  localparam int NCH = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      cmd_word;
  logic [31:0]      data_out;
  logic             mem_full;
  logic [NCH*64-1:0] ber_samp;
  logic [NCH*64-1:0] ber_error;
  logic [31:0]      mem_data;
  logic             rst_out;
  logic [NCH-1:0]   enb_tx;
  logic [NCH-1:0]   enb_rx;
  logic [NCH*2-1:0] phase_sel;
  logic             run_log;
  logic             read_log;
  logic [14:0]      addr_log;

  file_register_nch dut (
    .clock               (clock),
    .reset               (reset),
    .i_cmd_from_micro    (cmd_word),
    .o_data_to_micro     (data_out),
    .i_mem_full          (mem_full),
    .i_ber_samp          (ber_samp),
    .i_ber_error         (ber_error),
    .i_data_log_from_mem (mem_data),
    .o_reset             (rst_out),
    .o_enb_tx            (enb_tx),
    .o_enb_rx            (enb_rx),
    .o_phase_sel         (phase_sel),
    .o_run_log           (run_log),
    .o_read_log          (read_log),
    .o_addr_log_to_mem   (addr_log)
  );

  always #5 clock = ~clock;

  localparam int S_DATA = 0, S_RST = 1, S_TX = 2, S_RX = 3, S_PH = 4,
                 S_RUN = 5, S_RDL = 6, S_ADDR = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_DATA:  return data_out;
      S_RST:   return 32'(rst_out);
      S_TX:    return 32'(enb_tx);
      S_RX:    return 32'(enb_rx);
      S_PH:    return 32'(phase_sel);
      S_RUN:   return 32'(run_log);
      S_RDL:   return 32'(read_log);
      default: return 32'(addr_log);
    endcase
  endfunction

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_cmp++;
        if (actual(sb[i].sig) !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc, actual(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int d, input int sig, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + d; e.sig = sig; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  // Strobe edge sampled at the next posedge; effects visible at cyc+1.
  task automatic issue(input logic [7:0] op, input logic [6:0] ch, input logic [15:0] v);
    cmd_word = {op, 1'b1, ch, v};
    @(posedge clock); #1;
    cmd_word[23] = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_word  = {OP_EN_TX, 1'b1, 7'h7F, 16'h0001};
    mem_full  = 1'b0;
    ber_samp  = '0;
    ber_error = '0;
    mem_data  = 32'h0;
    repeat (3) @(posedge clock);
    #1;

    // Strobe held high through reset release must not execute.
    for (int s = 0; s < 8; s++) begin
      chk(1, s, 32'h0, "reset_state");
      chk(3, s, 32'h0, "held_strobe_no_exec");
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cmd_word = 32'h0;
    repeat (2) @(posedge clock);
    #1;

    chk(0, S_TX, 32'h0, "en_tx_before");
    chk(1, S_TX, 32'h2, "en_tx_ch1");
    issue(OP_EN_TX, 7'd1, 16'h1);

    chk(1, S_RX, 32'h3, "en_rx_bcast");
    issue(OP_EN_RX, 7'h7F, 16'h1);

    chk(1, S_PH, 32'hF, "ph_sel_bcast");
    issue(OP_PH_SEL, 7'h7F, 16'h3);
    chk(1, S_PH, 32'hD, "ph_sel_ch0");
    issue(OP_PH_SEL, 7'd0, 16'h1);

    chk(1, S_RUN, 32'h1, "run_mem");
    issue(OP_RUN_MEM, 7'd0, 16'h1);

    mem_full = 1'b1;
    chk(1, S_DATA, 32'h1, "is_full");
    issue(OP_IS_FULL, 7'd0, 16'h0);

    ber_error[63:0] = 64'h0000_0005_0000_0009;
    chk(1, S_DATA, 32'h9, "ber_e_low");
    issue(OP_BER_E, 7'd0, 16'h0);
    ber_error[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    chk(1, S_DATA, 32'h5, "ber_high_snapshot");
    issue(OP_BER_HIGH, 7'd0, 16'h0);

    ber_samp[127:64] = 64'h1234_5678_9ABC_DEF0;
    chk(1, S_DATA, 32'h9ABC_DEF0, "ber_s_ch1_low");
    issue(OP_BER_S, 7'd1, 16'h0);
    chk(1, S_DATA, 32'h1234_5678, "ber_s_ch1_high");
    issue(OP_BER_HIGH, 7'd1, 16'h0);

    chk(1, S_DATA, 32'h0, "ber_s_oor_low");
    issue(OP_BER_S, 7'd5, 16'h0);
    chk(1, S_DATA, 32'h0, "ber_oor_high_cleared");
    issue(OP_BER_HIGH, 7'd0, 16'h0);

    chk(1, S_TX, 32'h2, "en_tx_oor_ignored");
    issue(OP_EN_TX, 7'd5, 16'h0);

    chk(1, S_DATA, 32'h0, "unknown_op_data");
    chk(1, S_TX, 32'h2, "unknown_op_tx");
    issue(8'h3F, 7'd0, 16'hFFFF);

    // Log read: 1-cycle request at N+1, data at N+1+MEM_LAT.
    mem_data = 32'h0000_CAFE;
    chk(1, S_RDL, 32'h1, "rd_mem_pulse");
    chk(1, S_ADDR, 32'h12, "rd_mem_addr");
    chk(2, S_RDL, 32'h0, "rd_mem_pulse_end");
    chk(2, S_DATA, 32'h0, "rd_mem_data_early");
    chk(3, S_DATA, 32'h0000_CAFE, "rd_mem_data");
    issue(OP_RD_MEM, 7'd0, 16'h0012);
    chk(1, S_TX, 32'h2, "mem_wait_edge_dropped");
    chk(1, S_DATA, 32'h0000_CAFE, "rd_mem_data_hold");
    issue(OP_EN_TX, 7'h7F, 16'h1);

    // Reset pulse, re-issued two cycles in.
    chk(0, S_RST, 32'h0, "rst_before");
    chk(1, S_RST, 32'h1, "rst_pulse_c1");
    chk(2, S_RST, 32'h1, "rst_pulse_c2");
    issue(OP_RESET, 7'd0, 16'h0);
    for (int d = 1; d <= 4; d++) chk(d, S_RST, 32'h1, "rst_reissue_high");
    chk(5, S_RST, 32'h0, "rst_reissue_end");
    chk(5, S_TX, 32'h2, "rst_other_regs");
    chk(5, S_PH, 32'hD, "rst_other_phase");
    issue(OP_RESET, 7'd0, 16'h0);
    repeat (5) @(posedge clock);
    #1;

`ifdef FR_ERR_FLAG_EN
    chk(1, S_DATA, 32'h7, "status_accum");
    issue(OP_STATUS, 7'd0, 16'h0);
    issue(8'h3F, 7'd0, 16'h0);
    chk(1, S_RX, 32'h3, "en_rx_oor_ignored");
    issue(OP_EN_RX, 7'd9, 16'h0);
    chk(1, S_DATA, 32'h3, "status_flags");
    issue(OP_STATUS, 7'd0, 16'h0);
    chk(1, S_DATA, 32'h0, "status_cleared");
    issue(OP_STATUS, 7'd0, 16'h0);
`else
    chk(1, S_DATA, 32'h0000_CAFE, "status_is_unknown");
    issue(OP_STATUS, 7'd0, 16'h0);
`endif

    repeat (3) @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
